// File: rtl/pkt_steer_rx.sv
// pkt_steer_rx: registers, parity-checks and steers multicast packets to peripheral ports, register writes and counter replies
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   pkt_data_in/vld_in/rdy_out        incoming packet stream
//   reply_key_in                      base key for counter reply packets
//   ctr_clr_in                        synchronous clear of all counters
//   prx_addr_out/wdata_out/en_out     register write (en is a one-cycle strobe)
//   dcp_data_out/vld_out/rdy_in       counter reply packet stream
//   per_data_out/vld_out/rdy_in       NUM_PER peripheral packet streams
//   CTR_INIT                          counter reset value (0 in normal use)
module pkt_steer_rx #(
    parameter int          PACKET_BITS = 72,
    parameter int          NUM_PER     = 4,
    parameter int          SEL_LSB     = 24,
    parameter int          SEL_BITS    = 2,
    parameter int          CTR_SEC     = 4,
    parameter logic [31:0] CTR_INIT    = '0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [PACKET_BITS-1:0]         pkt_data_in,
    input  logic                           pkt_vld_in,
    output logic                           pkt_rdy_out,
    input  logic [31:0]                    reply_key_in,
    input  logic                           ctr_clr_in,
    output logic [7:0]                     prx_addr_out,
    output logic [31:0]                    prx_wdata_out,
    output logic                           prx_en_out,
    output logic [PACKET_BITS-1:0]         dcp_data_out,
    output logic                           dcp_vld_out,
    input  logic                           dcp_rdy_in,
    output logic [NUM_PER*PACKET_BITS-1:0] per_data_out,
    output logic [NUM_PER-1:0]             per_vld_out,
    input  logic [NUM_PER-1:0]             per_rdy_in
);
    localparam int NCTR = NUM_PER + 3;

    logic                   s_full, r_full;
    logic [PACKET_BITS-1:0] s_data, r_data;
    logic [31:0]            ctr [NCTR];
    logic [NCTR-1:0]        inc;
    logic [SEL_BITS-1:0]    sel;
    logic                   pld, cfg, par_ok, routable, fwd, bad, unr, wr, rd, r_load, leaving;
    logic [31:0]            rk, rval;

    assign pld      = s_data[1];
    assign cfg      = s_data[4];
    assign sel      = s_data[SEL_LSB +: SEL_BITS];
    assign par_ok   = pld ? ^s_data : ^s_data[39:0];
    assign routable = 32'(sel) < NUM_PER;

    // Mutually exclusive dispositions of the head of S, highest priority first.
    assign bad    = s_full && !par_ok;
    assign unr    = s_full && par_ok && !cfg && !routable;
    assign fwd    = s_full && par_ok && !cfg && routable;
    assign wr     = s_full && par_ok && cfg && pld;
    assign rd     = s_full && par_ok && cfg && !pld;
    assign r_load = rd && (!r_full || dcp_rdy_in);

    assign per_vld_out  = fwd ? NUM_PER'(1'b1) << sel : '0;
    assign per_data_out = {NUM_PER{s_data}};
    assign leaving      = bad || unr || wr || r_load || |(per_vld_out & per_rdy_in);
    assign pkt_rdy_out  = !s_full || leaving;

    assign prx_en_out    = wr;
    assign prx_addr_out  = s_data[15:8];
    assign prx_wdata_out = s_data[71:40];

    assign dcp_vld_out  = r_full;
    assign dcp_data_out = r_data;

    // Counter order: ports 0..NUM_PER-1, config, parity drop, unroutable drop.
    assign inc = {unr, bad, wr || r_load, per_vld_out & per_rdy_in};

    assign rk = reply_key_in | {25'b0, s_data[14:8]};

    // Unmatched section or index out of range falls through to the marker value.
    always_comb begin
        rval = 32'hdead_beef;
        for (int i = 0; i < NCTR; i++)
            if (s_data[14:12] == 3'(CTR_SEC) && s_data[11:8] == 4'(i)) rval = ctr[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_full <= 1'b0;
            s_data <= '0;
        end else if (pkt_vld_in && pkt_rdy_out) begin
            s_full <= 1'b1;
            s_data <= pkt_data_in;
        end else if (leaving) begin
            s_full <= 1'b0;
        end
    end

    // Header bit 0 makes the reply's overall parity odd.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (r_load) begin
            r_full <= 1'b1;
            r_data <= {rval, rk, 7'b001_1001, ^{rval, rk}};
        end else if (dcp_rdy_in) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCTR; i++) ctr[i] <= CTR_INIT;
        end else begin
            for (int i = 0; i < NCTR; i++) ctr[i] <= ctr_clr_in ? '0 : ctr[i] + 32'(inc[i]);
        end
    end
endmodule
